tone_generator: RTL and testbench



---
 rtl/tone_generator.sv | 151 +++++++++++++++
 tb/tb_tone_generator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_generator.sv
// tone_generator
//   Multi-channel DDS test-tone source for the codec DAC path. Each channel
//   owns a phase accumulator that advances once per codec frame, which is a
//   rising edge of the DAC LR clock. The accumulator phase is turned into a
//   square, sawtooth or triangle sample, then arithmetically attenuated.
//
// Ports
//   clk           system clock
//   Reset         asynchronous active-low reset
//   lrck          codec DAC LR clock (asynchronous to clk)
//   enable        1 = run, 0 = hold every channel silent with phase cleared
//   mode          00 square, 01 saw, 10 triangle, 11 silence
//   duty          square high-time in 1/256 of a period
//   atten         arithmetic right shift applied to every sample
//   freq_word     per-channel phase increment, channel n at [n*ACC_W +: ACC_W]
//   sample_data   per-channel sample, channel n at [n*DATA_W +: DATA_W]
//   sample_valid  one-cycle strobe marking new sample_data
//   sample_count  number of frame events since reset
module tone_generator #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 24
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         lrck,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [7:0]                   duty,
    input  logic [3:0]                   atten,
    input  logic [CHANNELS*ACC_W-1:0]    freq_word,
    output logic [CHANNELS*DATA_W-1:0]   sample_data,
    output logic                         sample_valid,
    output logic [31:0]                  sample_count
);

    localparam logic [DATA_W-1:0] WAVE_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] WAVE_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] WAVE_ZERO = {DATA_W{1'b0}};

    // Map the unsigned phase u (top DATA_W accumulator bits) to an
    // attenuated two's-complement sample for the selected waveform.
    function automatic logic [DATA_W-1:0] wave_f(
        input logic [DATA_W-1:0] phase_s,
        input logic [1:0]        sel_s,
        input logic [7:0]        duty_lvl_s,
        input logic [3:0]        shift_s
    );
        logic [DATA_W-1:0] tri_s;
        logic [DATA_W-1:0] raw_s;
        tri_s = {phase_s[DATA_W-2:0], 1'b0};
        // Second half of the period folds the ramp back down.
        if (phase_s[DATA_W-1]) begin
            tri_s = ~tri_s;
        end else begin
            tri_s = tri_s;
        end
        case (sel_s)
            2'b00:   raw_s = (phase_s[DATA_W-1 -: 8] < duty_lvl_s) ? WAVE_MAX : WAVE_MIN;
            2'b01:   raw_s = {~phase_s[DATA_W-1], phase_s[DATA_W-2:0]};
            2'b10:   raw_s = {~tri_s[DATA_W-1], tri_s[DATA_W-2:0]};
            default: raw_s = WAVE_ZERO;
        endcase
        return $unsigned($signed(raw_s) >>> shift_s);
    endfunction

    logic                s1_r;
    logic                s2_r;
    logic                s3_r;
    logic                event_s;
    logic                event_d_r;
    logic [ACC_W-1:0]    acc_r [CHANNELS];
    logic [DATA_W-1:0]   wave_s [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] data_r;
    logic                valid_r;
    logic [31:0]         count_r;

    // Frame event: rising edge of the synchronised LR clock.
    assign event_s = s2_r & ~s3_r;

    // Two-flop synchroniser for lrck plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= lrck;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Phase accumulators, frame counter and the output-compute strobe.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int n = 0; n < CHANNELS; n++) begin
                acc_r[n] <= {ACC_W{1'b0}};
            end
            count_r   <= 32'd0;
            event_d_r <= 1'b0;
        end else begin
            event_d_r <= event_s;
            if (event_s) begin
                count_r <= count_r + 32'd1;
                for (int n = 0; n < CHANNELS; n++) begin
                    if (enable) begin
                        acc_r[n] <= acc_r[n] + freq_word[n*ACC_W +: ACC_W];
                    end else begin
                        acc_r[n] <= {ACC_W{1'b0}};
                    end
                end
            end
        end
    end

    // Per-channel waveform from the freshly updated phase; the controls are
    // only consumed in the cycle before the sample register loads.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            wave_s[n] = WAVE_ZERO;
            if (enable) begin
                wave_s[n] = wave_f(acc_r[n][ACC_W-1 -: DATA_W], mode, duty, atten);
            end else begin
                wave_s[n] = WAVE_ZERO;
            end
        end
    end

    // Output sample register and its one-cycle valid strobe.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            data_r  <= {(CHANNELS*DATA_W){1'b0}};
            valid_r <= 1'b0;
        end else begin
            valid_r <= event_d_r;
            if (event_d_r) begin
                for (int n = 0; n < CHANNELS; n++) begin
                    data_r[n*DATA_W +: DATA_W] <= wave_s[n];
                end
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign sample_data  = data_r;
    assign sample_valid = valid_r;
    assign sample_count = count_r;

endmodule

// File: tb/tb_tone_generator.sv
module tb_tone_generator;

    localparam int DW = 16;
    localparam int CH = 2;
    localparam int AW = 24;
    localparam longint ACC_MASK = 64'h0000_0000_00FF_FFFF;

    logic               clk = 1'b0;
    logic               Reset;
    logic               lrck;
    logic               enable;
    logic [1:0]         mode;
    logic [7:0]         duty;
    logic [3:0]         atten;
    logic [CH*AW-1:0]   freq_word;
    logic [CH*DW-1:0]   sample_data;
    logic               sample_valid;
    logic [31:0]        sample_count;

    int     total = 0;
    int     bad   = 0;
    longint m_acc [CH];
    longint m_count;
    int     frames;
    int     vcount = 0;
    int     vbase;
    logic   valid_prev = 1'b0;

    tone_generator #(.DATA_W(DW), .CHANNELS(CH), .ACC_W(AW)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .lrck         (lrck),
        .enable       (enable),
        .mode         (mode),
        .duty         (duty),
        .atten        (atten),
        .freq_word    (freq_word),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    // Count cycles with sample_valid high and flag any strobe longer than one cycle.
    always @(negedge clk) begin
        if (sample_valid) vcount++;
        if (Reset) begin
            total++;
            assert (!(sample_valid && valid_prev)) else begin
                bad++;
                $error("FAIL valid_width observed=2+ cycles expected=1");
            end
        end
        valid_prev = sample_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference sample: waveform shapes written as plain signed arithmetic.
    function automatic logic [15:0] model_sample(input longint acc);
        int u;
        int ph8;
        int v;
        u   = int'(acc >> 8);
        ph8 = int'(acc >> 16);
        if (!enable) v = 0;
        else begin
            case (mode)
                2'd0:    v = (ph8 < int'(duty)) ? 32767 : -32768;
                2'd1:    v = u - 32768;
                2'd2:    v = (u < 32768) ? (2 * u - 32768) : (98303 - 2 * u);
                default: v = 0;
            endcase
        end
        v = v >>> atten;
        return v[15:0];
    endfunction

    task automatic set_fw(input logic [AW-1:0] f0, input logic [AW-1:0] f1);
        freq_word = {f1, f0};
    endtask

    // One lrck period: rise away from the clock edge, check latency and samples.
    task automatic frame();
        @(negedge clk);
        #($urandom_range(1, 3));
        lrck = 1'b1;
        for (int c = 0; c < CH; c++) begin
            if (enable) m_acc[c] = (m_acc[c] + longint'(freq_word[c*AW +: AW])) & ACC_MASK;
            else        m_acc[c] = 0;
        end
        m_count = (m_count + 1) & 64'hFFFF_FFFF;
        frames++;
        @(posedge clk);                       // E0: lrck captured
        @(posedge clk); #1;                   // E1
        chk("valid_e1", {31'd0, sample_valid}, 32'd0);
        @(posedge clk); #1;                   // E2
        chk("valid_e2", {31'd0, sample_valid}, 32'd0);
        chk("count", sample_count, m_count[31:0]);
        @(posedge clk); #1;                   // E3
        chk("valid_e3", {31'd0, sample_valid}, 32'd1);
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("data_ch%0d", c), {16'd0, sample_data[c*DW +: DW]},
                {16'd0, model_sample(m_acc[c])});
        end
        @(posedge clk); #1;                   // E4
        chk("valid_e4", {31'd0, sample_valid}, 32'd0);
        lrck = 1'b0;
        repeat ($urandom_range(3, 8)) @(posedge clk);
    endtask

    initial begin
        Reset = 1'b0; lrck = 1'b0; enable = 1'b0; mode = 2'd0;
        duty = 8'd128; atten = 4'd0; freq_word = '0;
        for (int c = 0; c < CH; c++) m_acc[c] = 0;
        m_count = 0; frames = 0;
        #23;
        chk("rst_data",  sample_data, 32'd0);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_count", sample_count, 32'd0);
        @(negedge clk); Reset = 1'b1;
        vbase = vcount;

        // Square at 50 %: 7 high, 8 low, then 8/8.
        enable = 1'b1; mode = 2'd0; duty = 8'd128; atten = 4'd0;
        set_fw(24'h100000, 24'h100000);
        repeat (40) frame();

        // Square with random duty and increments.
        for (int i = 0; i < 10; i++) begin
            duty = 8'($urandom_range(0, 255));
            set_fw(24'($urandom), 24'($urandom));
            frame();
        end
        duty = 8'd0;
        frame();
        chk("duty0", {16'd0, sample_data[15:0]}, 32'h8000);

        // Sawtooth from zero phase, full wrap.
        enable = 1'b0; frame();
        enable = 1'b1; mode = 2'd1; set_fw(24'h100000, 24'h100000);
        frame();
        chk("saw_first", {16'd0, sample_data[15:0]}, 32'h9000);
        repeat (17) frame();

        // Triangle, then the same with atten = 1.
        enable = 1'b0; frame();
        enable = 1'b1; mode = 2'd2;
        frame();
        chk("tri_first", {16'd0, sample_data[15:0]}, 32'h0000A000);
        repeat (15) frame();
        atten = 4'd1;
        enable = 1'b0; frame();
        enable = 1'b1;
        frame();
        chk("tri_half", {16'd0, sample_data[15:0]}, 32'h0000D000);
        repeat (15) frame();

        // Independent channels, then disable for 3 frames.
        atten = 4'd0; mode = 2'd1; set_fw(24'h100000, 24'h200000);
        repeat (8) frame();
        enable = 1'b0;
        repeat (3) frame();
        enable = 1'b1;
        frame();
        chk("restart_ch0", {16'd0, sample_data[15:0]},  32'h9000);
        chk("restart_ch1", {16'd0, sample_data[31:16]}, 32'hA000);

        // Random everything, including silence and deep attenuation.
        for (int i = 0; i < 30; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            mode   = 2'($urandom);
            duty   = 8'($urandom);
            atten  = 4'($urandom);
            set_fw(24'($urandom), 24'($urandom));
            frame();
        end

        // Frame counter wrap.
        @(negedge clk);
        force dut.count_r = 32'hFFFF_FFFF;
        #1 release dut.count_r;
        m_count = 64'hFFFF_FFFF;
        frame();
        chk("count_wrap", sample_count, 32'd0);

        chk("valid_pulses", 32'(vcount - vbase), 32'(frames));

        // Reset in the middle of an output strobe.
        enable = 1'b1; mode = 2'd1; atten = 4'd0; set_fw(24'h100000, 24'h300000);
        @(negedge clk); #2 lrck = 1'b1;
        repeat (4) @(posedge clk);
        #2 Reset = 1'b0;
        #1;
        chk("midrst_data",  sample_data, 32'd0);
        chk("midrst_valid", {31'd0, sample_valid}, 32'd0);
        chk("midrst_count", sample_count, 32'd0);
        lrck = 1'b0;
        #17 Reset = 1'b1;
        for (int c = 0; c < CH; c++) m_acc[c] = 0;
        m_count = 0; frames = 0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("post_rst_quiet", {31'd0, sample_valid}, 32'd0);
        end
        vbase = vcount;
        repeat (3) frame();
        chk("post_rst_saw", {16'd0, sample_data[31:16]}, 32'h1000);
        chk("post_rst_pulses", 32'(vcount - vbase), 32'(frames));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
